// File: rtl/display_scheduler.sv
// Frame sequencer for the six-digit seven-segment clock display. It snapshots the time or the edit buffer,
// strobes one digit per slot into DisplaySegment, and blinks the edited field. Option macro: LEADING_ZERO_BLANK_EN.
module display_scheduler #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] time_bcd,
    input  logic [23:0] set_bcd,
    input  logic        set_mode,
    input  logic [1:0]  field_sel,
    input  logic        freeze,
    output logic [5:0]  hexSeg,
    output logic [3:0]  valueIn0,
    output logic [3:0]  valueIn1,
    output logic [3:0]  valueIn2,
    output logic [3:0]  valueIn3,
    output logic [3:0]  valueIn4,
    output logic [3:0]  valueIn5,
    output logic        frame_done
);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} stateT;

    stateT              state, stateNext;
    logic [23:0]        snapshot, snapshotNext;
    logic               frameSetMode, frameSetModeNext;
    logic [1:0]         frameField, frameFieldNext;
    logic               frameVis, frameVisNext;
    logic [2:0]         slotIdx, slotIdxNext;
    logic [SCAN_W-1:0]  slotCnt, slotCntNext;
    logic [BLINK_W-1:0] blinkCnt;
    logic               blinkVis;
    logic [5:0][3:0]    values, valuesNext;
    logic [5:0]         hexSegNext;
    logic               frameDoneNext;
    logic               lzBlankH1;

    function automatic logic [3:0] digitOf(input logic [23:0] snap, input logic [2:0] k);
        return snap[{k, 2'b00} +: 4];
    endfunction

    // field_sel encodes the digit pair as k/2, so field 3 can never match a digit
    function automatic logic [5:0] slotMask(input logic [2:0] k, input logic setMode,
                                            input logic [1:0] field, input logic vis,
                                            input logic lzBlank);
        logic blank;
        blank = (setMode && !vis && (field == k[2:1])) || (lzBlank && (k == 3'd5));
        return blank ? 6'd0 : (6'd1 << k);
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    assign lzBlankH1 = (snapshot[23:20] == 4'd0);
`else
    assign lzBlankH1 = 1'b0;
`endif

    assign valueIn0 = values[0];
    assign valueIn1 = values[1];
    assign valueIn2 = values[2];
    assign valueIn3 = values[3];
    assign valueIn4 = values[4];
    assign valueIn5 = values[5];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blinkCnt <= '0;
            blinkVis <= 1'b1;
        end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt <= '0;
            blinkVis <= ~blinkVis;
        end else begin
            blinkCnt <= blinkCnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext        = state;
        snapshotNext     = snapshot;
        frameSetModeNext = frameSetMode;
        frameFieldNext   = frameField;
        frameVisNext     = frameVis;
        slotIdxNext      = slotIdx;
        slotCntNext      = slotCnt;
        valuesNext       = values;
        hexSegNext       = hexSeg;
        frameDoneNext    = 1'b0;
        case (state)
            IDLE: begin
                hexSegNext = '0;
                stateNext  = LOAD;
            end
            LOAD: begin
                // slot 0 is entered on this same edge, so it uses the incoming snapshot and mode
                if (!freeze) snapshotNext = set_mode ? set_bcd : time_bcd;
                frameSetModeNext = set_mode;
                frameFieldNext   = field_sel;
                frameVisNext     = blinkVis;
                slotIdxNext      = 3'd0;
                slotCntNext      = '0;
                valuesNext[0]    = snapshotNext[3:0];
                hexSegNext       = slotMask(3'd0, set_mode, field_sel, blinkVis, 1'b0);
                stateNext        = SCAN;
            end
            SCAN: begin
                if (slotCnt == SCAN_LAST) begin
                    slotCntNext = '0;
                    if (slotIdx == 3'd5) begin
                        hexSegNext    = '0;
                        frameDoneNext = 1'b1;
                        stateNext     = DONE;
                    end else begin
                        slotIdxNext             = slotIdx + 3'd1;
                        valuesNext[slotIdxNext] = digitOf(snapshot, slotIdxNext);
                        hexSegNext              = slotMask(slotIdxNext, frameSetMode, frameField,
                                                           frameVis, lzBlankH1);
                    end
                end else begin
                    slotCntNext = slotCnt + SCAN_W'(1);
                end
            end
            DONE: begin
                hexSegNext = '0;
                stateNext  = LOAD;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snapshot     <= '0;
            frameSetMode <= 1'b0;
            frameField   <= 2'd3;
            frameVis     <= 1'b1;
            slotIdx      <= '0;
            slotCnt      <= '0;
            values       <= '0;
            hexSeg       <= '0;
            frame_done   <= 1'b0;
        end else begin
            snapshot     <= snapshotNext;
            frameSetMode <= frameSetModeNext;
            frameField   <= frameFieldNext;
            frameVis     <= frameVisNext;
            slotIdx      <= slotIdxNext;
            slotCnt      <= slotCntNext;
            values       <= valuesNext;
            hexSeg       <= hexSegNext;
            frame_done   <= frameDoneNext;
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with SCAN_DIV=2 (14-cycle frames) and BLINK_DIV=40.
module tb_display_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] time_bcd;
    logic [23:0] set_bcd;
    logic        set_mode;
    logic [1:0]  field_sel;
    logic        freeze;
    logic [5:0]  hexSeg;
    logic [3:0]  valueIn0, valueIn1, valueIn2, valueIn3, valueIn4, valueIn5;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    display_scheduler #(.SCAN_DIV(2), .BLINK_DIV(40)) dut (
        .clock(clock), .reset(reset),
        .time_bcd(time_bcd), .set_bcd(set_bcd), .set_mode(set_mode),
        .field_sel(field_sel), .freeze(freeze), .hexSeg(hexSeg),
        .valueIn0(valueIn0), .valueIn1(valueIn1), .valueIn2(valueIn2),
        .valueIn3(valueIn3), .valueIn4(valueIn4), .valueIn5(valueIn5),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic tickTo(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkValues(input string tag, input logic [23:0] exp);
        check({tag, "_v0"}, 32'(valueIn0), 32'(exp[3:0]));
        check({tag, "_v1"}, 32'(valueIn1), 32'(exp[7:4]));
        check({tag, "_v2"}, 32'(valueIn2), 32'(exp[11:8]));
        check({tag, "_v3"}, 32'(valueIn3), 32'(exp[15:12]));
        check({tag, "_v4"}, 32'(valueIn4), 32'(exp[19:16]));
        check({tag, "_v5"}, 32'(valueIn5), 32'(exp[23:20]));
    endtask

    initial begin
        reset     = 1'b0;
        time_bcd  = 24'h123456;
        set_bcd   = 24'h000000;
        set_mode  = 1'b0;
        field_sel = 2'd3;
        freeze    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_hexseg", 32'(hexSeg), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        checkValues("rst", 24'h000000);
        reset = 1'b1;
        cyc   = 0;

        // frame 1: 0x123456
        tickTo(1);
        check("idle_hexseg", 32'(hexSeg), 32'd0);
        for (int c = 2; c <= 13; c++) begin
            tickTo(c);
            check("f1_hexseg", 32'(hexSeg), 32'(1 << ((c - 2) / 2)));
        end
        checkValues("f1", 24'h123456);
        tickTo(14);
        check("f1_done", 32'(frame_done), 32'd1);
        check("f1_done_hexseg", 32'(hexSeg), 32'd0);
        tickTo(15);
        check("f1_load_done", 32'(frame_done), 32'd0);
        tickTo(16);
        check("f2_slot0", 32'(hexSeg), 32'd1);

        // time changes mid-scan; frame 2 keeps the old digits
        tickTo(17);
        time_bcd = 24'h235959;
        tickTo(20);
        check("f2_v2_old", 32'(valueIn2), 32'd4);
        tickTo(24);
        check("f2_v5_old", 32'(valueIn5), 32'd1);
        tickTo(27);
        check("f2_predone", 32'(frame_done), 32'd0);
        tickTo(28);
        check("f2_done", 32'(frame_done), 32'd1);
        tickTo(30);
        check("f3_v0", 32'(valueIn0), 32'd9);
        check("f3_slot0", 32'(hexSeg), 32'd1);
        tickTo(40);
        checkValues("f3", 24'h235959);
        check("f3_slot5", 32'(hexSeg), 32'd32);

        // freeze at the frame-4 load
        tickTo(42);
        check("f3_done", 32'(frame_done), 32'd1);
        freeze   = 1'b1;
        time_bcd = 24'h111111;
        tickTo(44);
        check("f4_frozen_v0", 32'(valueIn0), 32'd9);
        freeze    = 1'b0;
        set_mode  = 1'b1;
        set_bcd   = 24'h101500;
        field_sel = 2'd1;
        tickTo(48);
        check("f4_slot2_unblanked", 32'(hexSeg), 32'd4);
        tickTo(54);
        checkValues("f4", 24'h235959);

        // set mode, minutes blinked; blink is off for loads at cycles 57 and 71
        tickTo(58);
        check("f5_slot0", 32'(hexSeg), 32'd1);
        tickTo(60);
        check("f5_slot1", 32'(hexSeg), 32'd2);
        tickTo(62);
        check("f5_slot2_blank", 32'(hexSeg), 32'd0);
        check("f5_v2", 32'(valueIn2), 32'd5);
        tickTo(64);
        check("f5_slot3_blank", 32'(hexSeg), 32'd0);
        check("f5_v3", 32'(valueIn3), 32'd1);
        tickTo(66);
        check("f5_slot4", 32'(hexSeg), 32'd16);
        tickTo(68);
        check("f5_slot5", 32'(hexSeg), 32'd32);
        checkValues("f5", 24'h101500);
        tickTo(76);
        check("f6_slot2_blank", 32'(hexSeg), 32'd0);
        tickTo(78);
        check("f6_slot3_blank", 32'(hexSeg), 32'd0);
        tickTo(80);
        check("f6_slot4", 32'(hexSeg), 32'd16);

        // blink visible again for the load at cycle 85
        tickTo(86);
        check("f7_slot0", 32'(hexSeg), 32'd1);
        tickTo(90);
        check("f7_slot2_vis", 32'(hexSeg), 32'd4);
        check("f7_v2", 32'(valueIn2), 32'd5);
        tickTo(92);
        check("f7_slot3_vis", 32'(hexSeg), 32'd8);
        check("f7_v3", 32'(valueIn3), 32'd1);

        // asynchronous reset in slot 3
        time_bcd  = 24'h091500;
        set_mode  = 1'b0;
        field_sel = 2'd3;
        #2;
        reset = 1'b0;
        #1;
        check("async_hexseg", 32'(hexSeg), 32'd0);
        check("async_done", 32'(frame_done), 32'd0);
        checkValues("async", 24'h000000);
        @(posedge clock);
        #1;
        check("held_rst_hexseg", 32'(hexSeg), 32'd0);
        reset = 1'b1;
        cyc   = 0;

        // restart from IDLE with a leading-zero hour
        tickTo(1);
        check("re_idle_hexseg", 32'(hexSeg), 32'd0);
        for (int c = 2; c <= 13; c++) begin
            tickTo(c);
`ifdef LEADING_ZERO_BLANK_EN
            check("lz_hexseg", 32'(hexSeg), (c >= 12) ? 32'd0 : 32'(1 << ((c - 2) / 2)));
`else
            check("lz_hexseg", 32'(hexSeg), 32'(1 << ((c - 2) / 2)));
`endif
        end
        checkValues("lz", 24'h091500);
        tickTo(14);
        check("lz_done", 32'(frame_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Frame sequencer for the six-digit seven-segment display of the digital clock. It takes a coherent snapshot of either the running time or the set-mode edit buffer, then strobes the digits one at a time into the DisplaySegment decoder by driving its `hexSeg` enable mask and `valueIn0..5` digit inputs. It also blinks the field being edited in set mode. It sits between the timekeeping/set logic and DisplaySegment.

## Interface
- `SCAN_DIV`, 1000: clock cycles each digit slot is held (≥1).
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period (≥1).

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `time_bcd`  in  24  running time {H1,H0,M1,M0,S1,S0}, 4-bit BCD each, S0 in [3:0].
- `set_bcd`  in  24  edit buffer, same packing.
- `set_mode`  in  1  1 = display `set_bcd` and blink the selected field.
- `field_sel`  in  2  blinked field: 0 = seconds (digits 0-1), 1 = minutes (2-3), 2 = hours (4-5), 3 = none.
- `freeze`  in  1  1 = keep the previous snapshot at the next frame start.
- `hexSeg`  out  6  one-hot digit strobe to DisplaySegment; all zero = no update.
- `valueIn0`..`valueIn5`  out  4 each  digit values to DisplaySegment.
- `frame_done`  out  1  one-cycle pulse after digit 5's slot ends.

## Operation
- FSM states: IDLE, LOAD, SCAN, DONE. Reset enters IDLE.
- IDLE → LOAD unconditionally on the next clock.
- LOAD lasts 1 cycle:
  - The snapshot register takes `set_mode ? set_bcd : time_bcd`, unless `freeze`=1, in which case it keeps its old value.
  - `set_mode`, `field_sel` and the blink phase are sampled into frame-local registers.
  - Next state is SCAN with slot index 0.
- SCAN: slot k (0..5) lasts exactly `SCAN_DIV` cycles.
  - At slot entry, `valueInk` is loaded with snapshot digit k. All other `valueIn` outputs hold their values.
  - `hexSeg` = (1<<k) for the whole slot, unless digit k is blanked. A blanked slot has `hexSeg`=0 but still takes its full time.
  - After slot 5, go to DONE.
- DONE lasts 1 cycle: `frame_done`=1, `hexSeg`=0, then LOAD.
- Blink:
  - A free-running counter toggles `blink_vis` every `BLINK_DIV` cycles. It resets to 0 with `blink_vis`=1 (visible).
  - Digit k is blanked when the sampled set_mode=1, the sampled blink_vis=0, and k is in the sampled field. field_sel=3 blanks nothing.
- Digits are passed through unmodified; non-BCD values (A-F) are not clamped.
- Frame length = 2 + 6·`SCAN_DIV` cycles (LOAD + 6 slots + DONE).
- Input changes during SCAN do not affect the current frame.

## Timing
- All outputs are registered. Reset values: `hexSeg`=0, `valueIn0..5`=0, `frame_done`=0, snapshot=0, slot counter=0, blink counter=0.
- First cycle after reset release: IDLE. Second: LOAD. Third: `hexSeg`=000001 and `valueIn0` = sampled digit 0.
- Source to output latency: the value sampled in LOAD appears on `valueInk` at cycle 1 + k·`SCAN_DIV` after LOAD.
- Reset asserted mid-frame: all outputs clear immediately, without waiting for a clock. The FSM returns to IDLE and the partial frame is discarded.
- A blink toggle during a frame takes effect at the next LOAD.
- If `freeze` and `set_mode` change in the same cycle as LOAD, the values present in that cycle are used.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: digit 5 (H1) is blanked (`hexSeg[5]` stays 0 for that slot) whenever its snapshot value is 0. Blink blanking still applies to digit 4 as usual.
  - Undefined: digit 5 is strobed like every other digit, including when it is 0.

## Test plan
(Bench uses `SCAN_DIV`=2, `BLINK_DIV`=40.)
- Reset release with `time_bcd`=0x123456, `set_mode`=0:
  - `hexSeg` is 000001 for 2 cycles starting at cycle 3, then 000010 … 100000.
  - `valueIn0`=6, `valueIn1`=5, `valueIn2`=4, `valueIn3`=3, `valueIn4`=2, `valueIn5`=1.
  - `frame_done` pulses once every 14 cycles.
- Change `time_bcd` to 0x235959 mid-SCAN:
  - The current frame keeps the old digits.
  - The next frame shows 9,5,9,5,3,2.
- `freeze`=1 at LOAD with `time_bcd` changed: outputs repeat the prior frame's values.
- `set_mode`=1, `set_bcd`=0x101500, `field_sel`=1, frames spanning a blink-off phase:
  - `hexSeg[2]` and `hexSeg[3]` stay 0 in blink-off frames.
  - Digits 0, 1, 4 and 5 still strobe.
  - In visible frames, `valueIn2`=5 and `valueIn3`=1.
- Assert `reset` during slot 3: `hexSeg`, `valueIn*` and `frame_done` go to 0 asynchronously. After release, the sequence restarts from IDLE.
- `time_bcd`=0x091500:
  - With `LEADING_ZERO_BLANK_EN`, `hexSeg[5]` is never asserted.
  - Without it, `hexSeg`=100000 for 2 cycles with `valueIn5`=0.
